// File: rtl/class_select_seq.sv
// Class-select sequencer for the HDC class-HV memory: training label capture plus binarization sweep.
// Optional feature: define CLASS_SEL_RANGE_CHECK_EN to reject and flag out-of-range training labels.
module class_select_seq #(
  parameter  int unsigned NUM_CLASSES = 26,
  localparam int unsigned CLASS_W     = ($clog2(NUM_CLASSES) > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_training_hdc_model,
  input  logic [CLASS_W-1:0] i_class_select_bits,
  input  logic               i_label_valid,
  input  logic               i_start_binarize,
  input  logic               i_bin_step_ready,
  output logic [CLASS_W-1:0] o_training_class_select_bits,
  output logic [CLASS_W-1:0] o_nonbin_class_select_bits,
  output logic [CLASS_W-1:0] o_binarized_class_counter,
  output logic               o_binarizing_class_hvs,
  output logic               o_sel_valid,
  output logic               o_binarize_done,
  output logic               o_busy,
  output logic               o_label_err
);

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CLASS_W-1:0] r_training_idx;
  logic [CLASS_W-1:0] r_counter;
  logic               r_binarizing;
  logic               r_sel_valid;
  logic               r_done;
  logic               r_busy;
`ifdef CLASS_SEL_RANGE_CHECK_EN
  logic               r_label_err;
`endif

  // Sequencer FSM; every status output is a register updated alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_training_idx <= '0;
      r_counter      <= '0;
      r_binarizing   <= 1'b0;
      r_sel_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
`ifdef CLASS_SEL_RANGE_CHECK_EN
      r_label_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start_binarize) begin
            // A label arriving with the start pulse is dropped.
            r_state      <= S_BIN;
            r_counter    <= '0;
            r_binarizing <= 1'b1;
            r_sel_valid  <= 1'b1;
            r_busy       <= 1'b1;
          end else if (i_training_hdc_model) begin
            if (i_label_valid) begin
`ifdef CLASS_SEL_RANGE_CHECK_EN
              if (32'(i_class_select_bits) >= NUM_CLASSES) begin
                r_label_err <= 1'b1;
                r_sel_valid <= 1'b0;
              end else begin
                r_training_idx <= i_class_select_bits;
                r_sel_valid    <= 1'b1;
              end
`else
              r_training_idx <= i_class_select_bits;
              r_sel_valid    <= 1'b1;
`endif
            end else begin
              r_sel_valid <= 1'b0;
            end
          end else begin
            r_training_idx <= '0;
            r_sel_valid    <= 1'b0;
          end
        end
        S_BIN: begin
          if (i_bin_step_ready) begin
            if (r_counter == LAST_CLASS) begin
              r_state      <= S_DONE;
              r_binarizing <= 1'b0;
              r_sel_valid  <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_counter <= r_counter + CLASS_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_counter   <= '0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_sel_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_counter    <= '0;
          r_binarizing <= 1'b0;
          r_sel_valid  <= 1'b0;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_training_class_select_bits = r_training_idx;
  assign o_binarized_class_counter    = r_counter;
  assign o_binarizing_class_hvs       = r_binarizing;
  assign o_sel_valid                  = r_sel_valid;
  assign o_binarize_done              = r_done;
  assign o_busy                       = r_busy;
  // Memory address mux straight from registers, no added latency.
  assign o_nonbin_class_select_bits   = r_binarizing ? r_counter : r_training_idx;
`ifdef CLASS_SEL_RANGE_CHECK_EN
  assign o_label_err                  = r_label_err;
`else
  assign o_label_err                  = 1'b0;
`endif

endmodule

// File: tb/tb_class_select_seq.sv
// Directed self-checking bench for class_select_seq (NUM_CLASSES = 26).
module tb_class_select_seq;

  localparam int unsigned NUM_CLASSES = 26;
  localparam int unsigned CLASS_W     = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               trn = 1'b0;
  logic [CLASS_W-1:0] csb = '0;
  logic               lv  = 1'b0;
  logic               sb  = 1'b0;
  logic               rdy = 1'b0;
  logic [CLASS_W-1:0] o_tidx;
  logic [CLASS_W-1:0] o_nonbin;
  logic [CLASS_W-1:0] o_cnt;
  logic               o_bin;
  logic               o_selv;
  logic               o_done;
  logic               o_busy;
  logic               o_err;

  int n_chk = 0;
  int n_err = 0;

  class_select_seq #(.NUM_CLASSES(NUM_CLASSES)) dut (
    .i_clk                        (clk),
    .i_rst                        (rst),
    .i_training_hdc_model         (trn),
    .i_class_select_bits          (csb),
    .i_label_valid                (lv),
    .i_start_binarize             (sb),
    .i_bin_step_ready             (rdy),
    .o_training_class_select_bits (o_tidx),
    .o_nonbin_class_select_bits   (o_nonbin),
    .o_binarized_class_counter    (o_cnt),
    .o_binarizing_class_hvs       (o_bin),
    .o_sel_valid                  (o_selv),
    .o_binarize_done              (o_done),
    .o_busy                       (o_busy),
    .o_label_err                  (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tidx"}, 32'(o_tidx), 0);
    chk({tag, "_nonbin"}, 32'(o_nonbin), 0);
    chk({tag, "_cnt"}, 32'(o_cnt), 0);
    chk({tag, "_bin"}, 32'(o_bin), 0);
    chk({tag, "_selv"}, 32'(o_selv), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  initial begin
    int exp_cnt;

    // Reset
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Training label capture, hold, and clear
    trn = 1'b1; lv = 1'b1; csb = 5'd7;
    tick();
    chk("cap7_tidx", 32'(o_tidx), 7);
    chk("cap7_nonbin", 32'(o_nonbin), 7);
    chk("cap7_selv", 32'(o_selv), 1);
    chk("cap7_busy", 32'(o_busy), 0);
    lv = 1'b0; csb = 5'd12;
    tick();
    chk("hold7_tidx", 32'(o_tidx), 7);
    chk("hold7_selv", 32'(o_selv), 0);
    trn = 1'b0;
    tick();
    chk("trn_low_tidx", 32'(o_tidx), 0);
    chk("trn_low_nonbin", 32'(o_nonbin), 0);

    // Full sweep with ready tied high; labels during the sweep are ignored
    trn = 1'b1; lv = 1'b1; csb = 5'd4;
    tick();
    chk("cap4_tidx", 32'(o_tidx), 4);
    lv = 1'b0; sb = 1'b1; rdy = 1'b1;
    tick();
    chk("sw_start_busy", 32'(o_busy), 1);
    chk("sw_start_bin", 32'(o_bin), 1);
    chk("sw_start_selv", 32'(o_selv), 1);
    chk("sw_start_cnt", 32'(o_cnt), 0);
    chk("sw_start_nonbin", 32'(o_nonbin), 0);
    sb = 1'b0; lv = 1'b1; csb = 5'd9; trn = 1'b0;
    for (int i = 1; i < 26; i++) begin
      tick();
      chk("sw_cnt", 32'(o_cnt), 32'(i));
      chk("sw_nonbin", 32'(o_nonbin), 32'(i));
    end
    lv = 1'b0; trn = 1'b1;
    tick();
    chk("sw_done", 32'(o_done), 1);
    chk("sw_done_bin", 32'(o_bin), 0);
    chk("sw_done_selv", 32'(o_selv), 0);
    chk("sw_done_busy", 32'(o_busy), 1);
    chk("sw_done_nonbin", 32'(o_nonbin), 4);
    sb = 1'b1; rdy = 1'b0;
    tick();
    chk("sw_idle_done", 32'(o_done), 0);
    chk("sw_idle_busy", 32'(o_busy), 0);
    chk("sw_idle_cnt", 32'(o_cnt), 0);
    chk("sw_idle_tidx", 32'(o_tidx), 4);
    sb = 1'b0;
    tick();
    chk("done_start_ignored", 32'(o_busy), 0);

    // Sweep with ready asserted one cycle in three
    sb = 1'b1;
    tick();
    chk("thr_start_cnt", 32'(o_cnt), 0);
    sb = 1'b0;
    exp_cnt = 0;
    for (int c = 0; c < 78; c++) begin
      rdy = ((c % 3) == 2);
      tick();
      if (rdy) exp_cnt++;
      if (exp_cnt < 26) begin
        chk("thr_cnt", 32'(o_cnt), 32'(exp_cnt));
        chk("thr_bin", 32'(o_bin), 1);
      end else begin
        chk("thr_done", 32'(o_done), 1);
      end
    end
    rdy = 1'b0;
    tick();
    chk("thr_idle_busy", 32'(o_busy), 0);

    // Start wins over a same-cycle label
    lv = 1'b1; csb = 5'd3; sb = 1'b1;
    tick();
    chk("race_busy", 32'(o_busy), 1);
    chk("race_tidx", 32'(o_tidx), 4);
    chk("race_nonbin", 32'(o_nonbin), 0);
    lv = 1'b0; sb = 1'b0; rdy = 1'b1;
    tick();
    tick();
    chk("mid_cnt", 32'(o_cnt), 2);

    // Asynchronous reset mid-sweep: immediate clear and no done pulse
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick();
    chk("async_rst_done", 32'(o_done), 0);
    rdy = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk_all_zero("after_async_rst");

    // Out-of-range label handling
    trn = 1'b1; lv = 1'b1; csb = 5'd30;
    tick();
`ifdef CLASS_SEL_RANGE_CHECK_EN
    chk("oor_err", 32'(o_err), 1);
    chk("oor_tidx", 32'(o_tidx), 0);
    chk("oor_selv", 32'(o_selv), 0);
`else
    chk("oor_err", 32'(o_err), 0);
    chk("oor_tidx", 32'(o_tidx), 30);
    chk("oor_selv", 32'(o_selv), 1);
`endif
    csb = 5'd2;
    tick();
    chk("inr_tidx", 32'(o_tidx), 2);
    chk("inr_selv", 32'(o_selv), 1);
`ifdef CLASS_SEL_RANGE_CHECK_EN
    chk("err_sticky", 32'(o_err), 1);
`else
    chk("err_tied", 32'(o_err), 0);
`endif
    lv = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
